// File: rtl/slice_packer_pkg.sv
// slice_packer_pkg: shared constants and helpers for the slice packer.
package slice_packer_pkg;
    localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    // LSB index of slot k inside a word of pf slots of iw bits each.
    function automatic int slot_lsb(input int k, input int iw, input int pf, input bit msb_first);
        return msb_first ? (pf - k - 1) * iw : k * iw;
    endfunction
endpackage

// File: rtl/slice_packer_if.sv
// slice_packer_if: narrow sample stream in, packed wide word out.
interface slice_packer_if #(
    parameter int IW = 5,
    parameter int PF = 4
);
    logic [IW-1:0]    data_in;
    logic             data_in_valid;
    logic             sync_in;
    logic             flush;
    logic [IW*PF-1:0] data_out;
    logic             data_out_valid;
    logic             sync_out;
    logic             misalign_err;
    modport master (
        output data_in, data_in_valid, sync_in, flush,
        input  data_out, data_out_valid, sync_out, misalign_err
    );
    modport slave (
        input  data_in, data_in_valid, sync_in, flush,
        output data_out, data_out_valid, sync_out, misalign_err
    );
endinterface

// File: rtl/slice_packer.sv
// slice_packer: packs PACK_FACTOR narrow samples into one wide word, frame-aligned by sync_in.
module slice_packer
    import slice_packer_pkg::*;
#(
    parameter string ARCHITECTURE     = "BEHAVIORAL",
    parameter int    INPUT_DATA_WIDTH = 5,
    parameter int    PACK_FACTOR      = 4,
    parameter bit    MSB_FIRST        = 1
) (
    input logic          clk,
    input logic          rst,
    slice_packer_if.slave bus
);
    localparam int IW = INPUT_DATA_WIDTH;
    localparam int PF = PACK_FACTOR;
    localparam int W  = IW * PF;
    localparam int CW = clog2(PF);
    if (ARCHITECTURE != ARCH_BEHAVIORAL) begin : g_bad_arch
        $error("slice_packer: unsupported ARCHITECTURE");
    end
    if (PF < 2 || IW < 1) begin : g_bad_size
        $error("slice_packer: PACK_FACTOR must be >= 2 and INPUT_DATA_WIDTH >= 1");
    end
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  asm, asm_n, asm_ins, first, word, dout;
    logic          pend, pend_n, start, nz, last, emit, err;
    logic          vout, sout, eout;
    // The assembly register only ever holds filled slots; everything else stays zero,
    // so a flushed partial word is already zero padded.
    always_comb begin
        start   = bus.data_in_valid & bus.sync_in;
        nz      = cnt != '0;
        last    = cnt == CW'(PF - 1);
        asm_ins = asm | (W'(bus.data_in) << slot_lsb(int'(cnt), IW, PF, MSB_FIRST));
        first   = W'(bus.data_in) << slot_lsb(0, IW, PF, MSB_FIRST);
        emit    = start ? (bus.flush & nz) : bus.data_in_valid ? (last | bus.flush) : (bus.flush & nz);
        err     = start & ~bus.flush & nz;
        word    = (bus.data_in_valid & ~start) ? asm_ins : asm;
        asm_n   = start ? first : emit ? '0 : bus.data_in_valid ? asm_ins : asm;
        cnt_n   = start ? CW'(1) : emit ? '0 : bus.data_in_valid ? cnt + CW'(1) : cnt;
        pend_n  = start | (pend & ~emit);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            asm  <= '0;
            pend <= 1'b0;
            dout <= '0;
            vout <= 1'b0;
            sout <= 1'b0;
            eout <= 1'b0;
        end else begin
            cnt  <= cnt_n;
            asm  <= asm_n;
            pend <= pend_n;
            vout <= emit;
            sout <= emit & pend;
            eout <= err;
            if (emit) dout <= word;
        end
    end
    assign bus.data_out       = dout;
    assign bus.data_out_valid = vout;
    assign bus.sync_out       = sout;
    assign bus.misalign_err   = eout;
endmodule

// File: tb/tb_slice_packer.sv
// tb_slice_packer: scoreboard bench driving an MSB-first and an LSB-first packer with identical stimulus.
module tb_slice_packer;
    typedef struct {
        int          due;
        logic [19:0] w;
        logic        s;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] din = '0;
    logic dv = 1'b0, sy = 1'b0, fl = 1'b0;
    int cyc = 0, total = 0, bad = 0;
    exp_t qm[$], ql[$];
    int eqm[$], eql[$];
    exp_t em, el;
    int   dm, dl;
    slice_packer_if #(.IW(5), .PF(4)) ifm ();
    slice_packer_if #(.IW(5), .PF(4)) ifl ();
    assign ifm.data_in = din;
    assign ifm.data_in_valid = dv;
    assign ifm.sync_in = sy;
    assign ifm.flush = fl;
    assign ifl.data_in = din;
    assign ifl.data_in_valid = dv;
    assign ifl.sync_in = sy;
    assign ifl.flush = fl;
    slice_packer #(.ARCHITECTURE("BEHAVIORAL"), .INPUT_DATA_WIDTH(5), .PACK_FACTOR(4), .MSB_FIRST(1))
        dut_m (.clk(clk), .rst(rst), .bus(ifm));
    slice_packer #(.ARCHITECTURE("BEHAVIORAL"), .INPUT_DATA_WIDTH(5), .PACK_FACTOR(4), .MSB_FIRST(0))
        dut_l (.clk(clk), .rst(rst), .bus(ifl));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", n, got, exp, cyc);
        end
    endtask
    // One cycle of stimulus; expectations are due one cycle after the sampling edge.
    task automatic step(input logic v, input logic [4:0] d, input logic s, input logic f,
                        input bit ex, input logic [19:0] wm, input logic [19:0] wl,
                        input logic es, input bit ee);
        @(negedge clk);
        dv = v; din = d; sy = s; fl = f;
        if (ex) begin
            qm.push_back('{cyc + 1, wm, es});
            ql.push_back('{cyc + 1, wl, es});
        end
        if (ee) begin
            eqm.push_back(cyc + 1);
            eql.push_back(cyc + 1);
        end
    endtask
    task automatic smp(input logic [4:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask
    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask
    always @(negedge clk) begin
        if (ifm.data_out_valid) begin
            if (qm.size() == 0) chk("m_unexpected_word", ifm.data_out, 32'hDEAD);
            else begin
                em = qm.pop_front();
                chk("m_word", ifm.data_out, em.w);
                chk("m_sync", ifm.sync_out, em.s);
                chk("m_time", cyc, em.due);
            end
        end
        if (ifm.misalign_err) begin
            if (eqm.size() == 0) chk("m_unexpected_misalign", cyc, 0);
            else begin
                dm = eqm.pop_front();
                chk("m_misalign_time", cyc, dm);
            end
        end
    end
    always @(negedge clk) begin
        if (ifl.data_out_valid) begin
            if (ql.size() == 0) chk("l_unexpected_word", ifl.data_out, 32'hDEAD);
            else begin
                el = ql.pop_front();
                chk("l_word", ifl.data_out, el.w);
                chk("l_sync", ifl.sync_out, el.s);
                chk("l_time", cyc, el.due);
            end
        end
        if (ifl.misalign_err) begin
            if (eql.size() == 0) chk("l_unexpected_misalign", cyc, 0);
            else begin
                dl = eql.pop_front();
                chk("l_misalign_time", cyc, dl);
            end
        end
    end
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_m_out", {ifm.data_out_valid, ifm.sync_out, ifm.misalign_err, ifm.data_out}, '0);
        chk("rst_l_out", {ifl.data_out_valid, ifl.sync_out, ifl.misalign_err, ifl.data_out}, '0);
        rst = 1'b0;
        smp(5'h01); smp(5'h02); smp(5'h03);
        step(1, 5'h04, 0, 0, 1, 20'h08864, 20'h20C41, 0, 0);
        idle();
        smp(5'h01); idle(); smp(5'h02); idle(); smp(5'h03); idle();
        step(1, 5'h04, 0, 0, 1, 20'h08864, 20'h20C41, 0, 0);
        idle(); idle();
        smp(5'h1F); smp(5'h1F);
        step(0, 5'h00, 0, 1, 1, 20'hFFC00, 20'h003FF, 0, 0);
        smp(5'h01); smp(5'h02); smp(5'h03);
        step(1, 5'h04, 0, 0, 1, 20'h08864, 20'h20C41, 0, 0);
        idle();
        smp(5'h01); smp(5'h02);
        step(1, 5'h0A, 1, 0, 0, '0, '0, 0, 1);
        smp(5'h0B); smp(5'h0C);
        step(1, 5'h0D, 0, 0, 1, 20'h52D8D, 20'h6B16A, 1, 0);
        idle();
        smp(5'h01); smp(5'h02); smp(5'h03);
        @(negedge clk); rst = 1'b1; dv = 1'b0;
        @(negedge clk); rst = 1'b0;
        idle();
        smp(5'h01); smp(5'h02); smp(5'h03);
        step(1, 5'h04, 0, 0, 1, 20'h08864, 20'h20C41, 0, 0);
        idle();
        smp(5'h01); smp(5'h02);
        step(1, 5'h0A, 1, 1, 1, 20'h08800, 20'h00041, 0, 0);
        smp(5'h0B); smp(5'h0C);
        step(1, 5'h0D, 0, 0, 1, 20'h52D8D, 20'h6B16A, 1, 0);
        step(0, 5'h00, 0, 1, 0, '0, '0, 0, 0);
        idle();
        smp(5'h01); smp(5'h02); smp(5'h03);
        step(1, 5'h04, 0, 1, 1, 20'h08864, 20'h20C41, 0, 0);
        step(1, 5'h1F, 0, 1, 1, 20'hF8000, 20'h0001F, 0, 0);
        repeat (5) idle();
        chk("m_words_left", qm.size(), 0);
        chk("l_words_left", ql.size(), 0);
        chk("m_misalign_left", eqm.size(), 0);
        chk("l_misalign_left", eql.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
